// File: rtl/ffd_pkg.sv
// Shared constants and helpers for the ffd_pipe register pipeline.
package ffd_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ffd_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module ffd_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             en_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             vld_in,
    output logic [WIDTH-1:0] q_out,
    output logic             vld_out
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    // A flush only kills the valid bit; data keeps moving with en_in.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_data <= RST_VAL;
            r_vld  <= 1'b0;
        end else begin
            if (en_in) begin
                r_data <= d_in;
            end
            if (clr_in) begin
                r_vld <= 1'b0;
            end else if (en_in) begin
                r_vld <= vld_in;
            end
        end
    end

    assign q_out   = r_data;
    assign vld_out = r_vld;

endmodule

// File: rtl/ffd_pipe.sv
// Stallable DEPTH-stage register pipeline with valid bits, flush and occupancy count.
// Define FFD_PIPE_TAPS_EN to expose every stage register on taps_out.
module ffd_pipe
    import ffd_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      en_in,
    input  logic                      clr_in,
    input  logic [WIDTH-1:0]          d_in,
    input  logic                      vld_in,
    output logic [WIDTH-1:0]          q_out,
    output logic                      vld_out,
    output logic [occ_w(DEPTH)-1:0]   occ_out
`ifdef FFD_PIPE_TAPS_EN
    ,
    output logic [WIDTH*DEPTH-1:0]    taps_out
`endif
);

    localparam int OCC_W = occ_w(DEPTH);

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic             w_vld  [DEPTH+1];
    logic [OCC_W-1:0] r_occ;

    assign w_data[0] = d_in;
    assign w_vld[0]  = vld_in;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        ffd_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst_in  (rst_in),
            .clr_in  (clr_in),
            .en_in   (en_in),
            .d_in    (w_data[k]),
            .vld_in  (w_vld[k]),
            .q_out   (w_data[k+1]),
            .vld_out (w_vld[k+1])
        );
`ifdef FFD_PIPE_TAPS_EN
        assign taps_out[k*WIDTH +: WIDTH] = w_data[k+1];
`endif
    end

    // Tracked incrementally so occ_out stays a plain register output.
    always_ff @(posedge clk) begin
        if (rst_in || clr_in) begin
            r_occ <= '0;
        end else if (en_in) begin
            r_occ <= r_occ + OCC_W'(vld_in) - OCC_W'(w_vld[DEPTH]);
        end
    end

    assign q_out   = w_data[DEPTH];
    assign vld_out = w_vld[DEPTH];
    assign occ_out = r_occ;

endmodule

// File: tb/tb_ffd_pipe.sv
// Directed bench for ffd_pipe (WIDTH=8, DEPTH=4, RST_VAL=8'h5A) with a per-cycle shadow check.
module tb_ffd_pipe;

    localparam int               W  = 8;
    localparam int               D  = 4;
    localparam logic [W-1:0]     RV = 8'h5A;

    logic         clk;
    logic         rst_in;
    logic         en_in;
    logic         clr_in;
    logic [W-1:0] d_in;
    logic         vld_in;
    logic [W-1:0] q_out;
    logic         vld_out;
    logic [2:0]   occ_out;
`ifdef FFD_PIPE_TAPS_EN
    logic [W*D-1:0] taps;
`endif

    int n_chk;
    int n_bad;

    // Shadow of the stage contents, stage 0 at index 0.
    logic [W-1:0] md [D];
    logic         mv [D];

    ffd_pipe #(
        .WIDTH   (W),
        .DEPTH   (D),
        .RST_VAL (RV)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .en_in    (en_in),
        .clr_in   (clr_in),
        .d_in     (d_in),
        .vld_in   (vld_in),
        .q_out    (q_out),
        .vld_out  (vld_out),
        .occ_out  (occ_out)
`ifdef FFD_PIPE_TAPS_EN
        ,
        .taps_out (taps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the shadow and compare.
    task automatic step(input logic r, input logic c, input logic e, input logic v,
                        input logic [W-1:0] d);
        int pc;
        @(negedge clk);
        rst_in = r;
        clr_in = c;
        en_in  = e;
        vld_in = v;
        d_in   = d;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < D; k++) begin
                md[k] = RV;
                mv[k] = 1'b0;
            end
        end else begin
            if (e) begin
                for (int k = D - 1; k > 0; k--) begin
                    md[k] = md[k-1];
                    mv[k] = mv[k-1];
                end
                md[0] = d;
                mv[0] = v;
            end
            if (c) begin
                for (int k = 0; k < D; k++) mv[k] = 1'b0;
            end
        end
        #1;
        pc = 0;
        for (int k = 0; k < D; k++) pc += int'(mv[k]);
        chk("shadow_q", 32'(q_out), 32'(md[D-1]));
        chk("shadow_vld", 32'(vld_out), 32'(mv[D-1]));
        chk("occ_popcount", 32'(occ_out), 32'(pc));
        chk("occ_le_depth", 32'(occ_out <= 3'(D)), 32'd1);
`ifdef FFD_PIPE_TAPS_EN
        for (int k = 0; k < D; k++) chk("taps", 32'(taps[k*W +: W]), 32'(md[k]));
`endif
    endtask

    initial begin
        logic [W-1:0] held_q;
        n_chk  = 0;
        n_bad  = 0;
        rst_in = 1'b1;
        clr_in = 1'b0;
        en_in  = 1'b1;
        vld_in = 1'b1;
        d_in   = 8'hFF;
        for (int k = 0; k < D; k++) begin
            md[k] = RV;
            mv[k] = 1'b0;
        end

        // Reset held two cycles with junk on the inputs; reset beats enable.
        step(1, 0, 1, 1, 8'hFF);
        step(1, 0, 1, 1, 8'hFF);
        chk("rst_q", 32'(q_out), 32'h5A);
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_occ", 32'(occ_out), 32'd0);

        // Streaming 01..08: first word out on the 4th edge, occupancy caps at 4.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 8'(i + 1));
            chk("stream_occ", 32'(occ_out), 32'((i + 1 < 4) ? i + 1 : 4));
            if (i >= 3) begin
                chk("stream_q", 32'(q_out), 32'(i - 2));
                chk("stream_vld", 32'(vld_out), 32'd1);
            end else begin
                chk("stream_fill_vld", 32'(vld_out), 32'd0);
            end
        end

        // Stall: A5 at edge 1, bubble at edge 2, en low for edges 3..5, out at edge 7.
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'hA5);
        step(0, 0, 1, 0, 8'h00);
        held_q = q_out;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 8'hC3);
            chk("stall_q_hold", 32'(q_out), 32'(held_q));
            chk("stall_occ_hold", 32'(occ_out), 32'd1);
            chk("stall_vld_hold", 32'(vld_out), 32'd0);
        end
        step(0, 0, 1, 0, 8'h00);
        chk("stall_e6_vld", 32'(vld_out), 32'd0);
        step(0, 0, 1, 0, 8'h00);
        chk("stall_e7_q", 32'(q_out), 32'hA5);
        chk("stall_e7_vld", 32'(vld_out), 32'd1);

        // Bubbles: alternating valid gives 1,0,1,0 at the output four edges later.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, ~i[0], 8'(8'h10 + i));
            if (i >= 3) begin
                chk("bubble_vld", 32'(vld_out), 32'(((i - 3) % 2) == 0));
                chk("bubble_occ", 32'(occ_out), 32'd2);
            end
        end

        // Flush a full pipe while shifting; the word offered with clr must never be valid.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'(8'h21 + i));
        chk("flush_full_occ", 32'(occ_out), 32'd4);
        step(0, 1, 1, 1, 8'h99);
        chk("flush_occ", 32'(occ_out), 32'd0);
        chk("flush_vld", 32'(vld_out), 32'd0);
        chk("flush_q_shift", 32'(q_out), 32'h22);
        step(0, 0, 1, 1, 8'h77);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        chk("flush_dead_q", 32'(q_out), 32'h99);
        chk("flush_dead_vld", 32'(vld_out), 32'd0);
        step(0, 0, 1, 0, 8'h00);
        chk("flush_next_q", 32'(q_out), 32'h77);
        chk("flush_next_vld", 32'(vld_out), 32'd1);
        chk("flush_next_occ", 32'(occ_out), 32'd1);

        // Mid-stream reset pulse, then a clean restart with 4-edge latency.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 8'(8'h31 + i));
        step(1, 0, 1, 1, 8'hEE);
        chk("midrst_q", 32'(q_out), 32'h5A);
        chk("midrst_vld", 32'(vld_out), 32'd0);
        chk("midrst_occ", 32'(occ_out), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'(8'h41 + i));
        chk("resume_q", 32'(q_out), 32'h41);
        chk("resume_vld", 32'(vld_out), 32'd1);
        chk("resume_occ", 32'(occ_out), 32'd4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
